// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780 4-bit character driver: command
// codes, default timing, state encodings and the power-up init ROM.
package lcd_pkg;

    localparam logic [7:0] CMD_FUNC_4BIT_2LINE = 8'h28;
    localparam logic [7:0] CMD_DISP_ON         = 8'h0C;
    localparam logic [7:0] CMD_CLEAR           = 8'h01;
    localparam logic [7:0] CMD_ENTRY_INC       = 8'h06;
    localparam logic [7:0] CMD_HOME            = 8'h02;

    // Default timing at 12 MHz
    localparam int DEF_T_POWERUP_CYC   = 480000;
    localparam int DEF_T_INIT_LONG_CYC = 49200;
    localparam int DEF_T_SHORT_CYC     = 1200;
    localparam int DEF_T_EPULSE_CYC    = 6;
    localparam int DEF_T_CHAR_CYC      = 480;
    localparam int DEF_T_HOME_CYC      = 19200;

    typedef enum logic [2:0] {
        ST_PWRUP     = 3'd0,
        ST_INIT_NIB  = 3'd1,
        ST_INIT_WAIT = 3'd2,
        ST_LOAD      = 3'd3,
        ST_NIB_HI    = 3'd4,
        ST_NIB_LO    = 3'd5,
        ST_EXEC_WAIT = 3'd6,
        ST_IDLE      = 3'd7
    } lcd_state_e;

    typedef enum logic [1:0] {
        PH_IDLE  = 2'd0,
        PH_SETUP = 2'd1,
        PH_PULSE = 2'd2,
        PH_HOLD  = 2'd3
    } strobe_phase_e;

    typedef enum logic [1:0] {
        W_LONG  = 2'd0,
        W_SHORT = 2'd1,
        W_CHAR  = 2'd2,
        W_HOME  = 2'd3
    } wait_sel_e;

    // One init step: a lone high nibble (single=1) or a full byte
    typedef struct packed {
        logic       single;
        logic [7:0] code;
        wait_sel_e  wsel;
    } init_step_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Power-up sequence: three 0x3 nibbles, 0x2 to enter 4-bit mode, then
    // function set, display on, clear and entry mode as full bytes.
    function automatic init_step_t init_rom(input logic [2:0] idx);
        init_step_t s;
        case (idx)
            3'd0:    s = '{1'b1, 8'h30, W_LONG};
            3'd1:    s = '{1'b1, 8'h30, W_SHORT};
            3'd2:    s = '{1'b1, 8'h30, W_SHORT};
            3'd3:    s = '{1'b1, 8'h20, W_SHORT};
            3'd4:    s = '{1'b0, CMD_FUNC_4BIT_2LINE, W_CHAR};
            3'd5:    s = '{1'b0, CMD_DISP_ON, W_CHAR};
            3'd6:    s = '{1'b0, CMD_CLEAR, W_HOME};
            default: s = '{1'b0, CMD_ENTRY_INC, W_CHAR};
        endcase
        return s;
    endfunction

endpackage

// File: rtl/lcd_char_driver_strobe.sv
// Single LCD nibble strobe: one setup cycle with RS/data driven, E high
// for T_EPULSE_CYC, then E low for T_EPULSE_CYC with data held.
module lcd_nibble_strobe
    import lcd_pkg::*;
#(
    parameter int T_EPULSE_CYC = DEF_T_EPULSE_CYC
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       rs,
    input  logic [3:0] nibble,
    output logic       done,
    output logic       lcd_e,
    output logic       lcd_rs,
    output logic [3:0] lcd_data
);

    localparam int CW = $clog2(T_EPULSE_CYC + 1);
    localparam logic [CW-1:0] PULSE_LOAD = CW'(T_EPULSE_CYC - 1);

    strobe_phase_e   phase_r;
    logic [CW-1:0]   cnt_r;
    logic            e_r;
    logic            rs_r;
    logic [3:0]      data_r;

    // done is raised in the last hold cycle so a following nibble can
    // start back-to-back without an extra idle cycle
    assign done     = (phase_r == PH_HOLD) && (cnt_r == {CW{1'b0}});
    assign lcd_e    = e_r;
    assign lcd_rs   = rs_r;
    assign lcd_data = data_r;

    // Setup / pulse / hold sequencer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_r <= PH_IDLE;
            cnt_r   <= {CW{1'b0}};
            e_r     <= 1'b0;
            rs_r    <= 1'b0;
            data_r  <= 4'h0;
        end else if (start) begin
            phase_r <= PH_SETUP;
            cnt_r   <= {CW{1'b0}};
            e_r     <= 1'b0;
            rs_r    <= rs;
            data_r  <= nibble;
        end else begin
            case (phase_r)
                PH_SETUP: begin
                    phase_r <= PH_PULSE;
                    e_r     <= 1'b1;
                    cnt_r   <= PULSE_LOAD;
                end
                PH_PULSE: begin
                    if (cnt_r == {CW{1'b0}}) begin
                        phase_r <= PH_HOLD;
                        e_r     <= 1'b0;
                        cnt_r   <= PULSE_LOAD;
                    end else begin
                        cnt_r   <= cnt_r - CW'(1);
                    end
                end
                PH_HOLD: begin
                    if (cnt_r == {CW{1'b0}}) begin
                        phase_r <= PH_IDLE;
                    end else begin
                        cnt_r   <= cnt_r - CW'(1);
                    end
                end
                default: begin
                    phase_r <= PH_IDLE;
                    e_r     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/lcd_char_driver.sv
// HD44780 4-bit character driver: runs power-up init, then serialises
// single character writes or home requests onto the LCD bus.
module lcd_char_driver
    import lcd_pkg::*;
#(
    parameter int T_POWERUP_CYC   = DEF_T_POWERUP_CYC,
    parameter int T_INIT_LONG_CYC = DEF_T_INIT_LONG_CYC,
    parameter int T_SHORT_CYC     = DEF_T_SHORT_CYC,
    parameter int T_EPULSE_CYC    = DEF_T_EPULSE_CYC,
    parameter int T_CHAR_CYC      = DEF_T_CHAR_CYC,
    parameter int T_HOME_CYC      = DEF_T_HOME_CYC
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] char,
    input  logic       writeChar,
    input  logic       home,
    output logic       ready,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_e,
    output logic [3:0] lcd_data
);

    localparam int MAX_CYC = max_int(max_int(max_int(T_POWERUP_CYC, T_INIT_LONG_CYC),
                                             max_int(T_SHORT_CYC, T_EPULSE_CYC)),
                                     max_int(T_CHAR_CYC, T_HOME_CYC));
    localparam int CNT_W = $clog2(MAX_CYC + 1);

    lcd_state_e        state_r;
    logic [CNT_W-1:0]  cnt_r;
    logic [2:0]        idx_r;
    logic              init_r;
    logic              ready_r;
    logic [7:0]        byte_r;
    logic              rs_r;
    logic              single_r;
    wait_sel_e         wsel_r;

    logic              strobe_start_s;
    logic [3:0]        strobe_nib_s;
    logic              strobe_done_s;
    init_step_t        next_step_s;

    // Execution waits are loaded as N-1 so the wait state lasts N cycles
    function automatic logic [CNT_W-1:0] wait_cnt(input wait_sel_e w);
        case (w)
            W_LONG:  return CNT_W'(T_INIT_LONG_CYC - 1);
            W_SHORT: return CNT_W'(T_SHORT_CYC - 1);
            W_HOME:  return CNT_W'(T_HOME_CYC - 1);
            default: return CNT_W'(T_CHAR_CYC - 1);
        endcase
    endfunction

    assign next_step_s = init_rom(idx_r + 3'd1);
    assign ready       = ready_r;
    assign lcd_rw      = 1'b0;

    // Strobe launch: high nibble on LOAD/INIT_NIB, low nibble chained on done
    always_comb begin
        strobe_start_s = 1'b0;
        strobe_nib_s   = byte_r[7:4];
        case (state_r)
            ST_INIT_NIB, ST_LOAD: begin
                strobe_start_s = 1'b1;
                strobe_nib_s   = byte_r[7:4];
            end
            ST_NIB_HI: begin
                strobe_start_s = strobe_done_s;
                strobe_nib_s   = byte_r[3:0];
            end
            default: begin
                strobe_start_s = 1'b0;
                strobe_nib_s   = byte_r[7:4];
            end
        endcase
    end

    // Main sequencer: power-up, init ROM walk, request handling, exec waits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= ST_PWRUP;
            cnt_r    <= {CNT_W{1'b0}};
            idx_r    <= 3'd0;
            init_r   <= 1'b1;
            ready_r  <= 1'b0;
            byte_r   <= 8'h00;
            rs_r     <= 1'b0;
            single_r <= 1'b0;
            wsel_r   <= W_CHAR;
        end else begin
            case (state_r)
                ST_PWRUP: begin
                    // counts up from the cleared reset value
                    if (cnt_r == CNT_W'(T_POWERUP_CYC - 1)) begin
                        state_r  <= ST_INIT_NIB;
                        idx_r    <= 3'd0;
                        byte_r   <= init_rom(3'd0).code;
                        single_r <= init_rom(3'd0).single;
                        wsel_r   <= init_rom(3'd0).wsel;
                        rs_r     <= 1'b0;
                    end else begin
                        cnt_r    <= cnt_r + CNT_W'(1);
                    end
                end
                ST_INIT_NIB: begin
                    state_r <= ST_NIB_LO;
                end
                ST_LOAD: begin
                    state_r <= ST_NIB_HI;
                end
                ST_NIB_HI: begin
                    if (strobe_done_s) begin
                        state_r <= ST_NIB_LO;
                    end else begin
                        state_r <= ST_NIB_HI;
                    end
                end
                ST_NIB_LO: begin
                    if (strobe_done_s) begin
                        state_r <= single_r ? ST_INIT_WAIT : ST_EXEC_WAIT;
                        cnt_r   <= wait_cnt(wsel_r);
                    end else begin
                        state_r <= ST_NIB_LO;
                    end
                end
                ST_INIT_WAIT, ST_EXEC_WAIT: begin
                    if (cnt_r == {CNT_W{1'b0}}) begin
                        if (init_r && (idx_r != 3'd7)) begin
                            idx_r    <= idx_r + 3'd1;
                            byte_r   <= next_step_s.code;
                            single_r <= next_step_s.single;
                            wsel_r   <= next_step_s.wsel;
                            rs_r     <= 1'b0;
                            state_r  <= next_step_s.single ? ST_INIT_NIB : ST_LOAD;
                        end else begin
                            init_r   <= 1'b0;
                            ready_r  <= 1'b1;
                            state_r  <= ST_IDLE;
                        end
                    end else begin
                        cnt_r <= cnt_r - CNT_W'(1);
                    end
                end
                ST_IDLE: begin
                    // home has priority; a simultaneous writeChar is dropped
                    if (home) begin
                        byte_r   <= CMD_HOME;
                        rs_r     <= 1'b0;
                        single_r <= 1'b0;
                        wsel_r   <= W_HOME;
                        ready_r  <= 1'b0;
                        state_r  <= ST_LOAD;
                    end else if (writeChar) begin
                        byte_r   <= char;
                        rs_r     <= 1'b1;
                        single_r <= 1'b0;
                        wsel_r   <= W_CHAR;
                        ready_r  <= 1'b0;
                        state_r  <= ST_LOAD;
                    end else begin
                        state_r  <= ST_IDLE;
                    end
                end
                default: begin
                    state_r <= ST_PWRUP;
                    ready_r <= 1'b0;
                    cnt_r   <= {CNT_W{1'b0}};
                end
            endcase
        end
    end

    lcd_nibble_strobe #(
        .T_EPULSE_CYC (T_EPULSE_CYC)
    ) u_strobe (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (strobe_start_s),
        .rs       (rs_r),
        .nibble   (strobe_nib_s),
        .done     (strobe_done_s),
        .lcd_e    (lcd_e),
        .lcd_rs   (lcd_rs),
        .lcd_data (lcd_data)
    );

endmodule

// File: tb/tb_lcd_char_driver.sv
// Self-checking bench for lcd_char_driver with scaled timing.
module tb_lcd_char_driver;

    localparam int TP  = 20;
    localparam int TL  = 10;
    localparam int TS  = 4;
    localparam int TE  = 2;
    localparam int TC  = 5;
    localparam int TH  = 12;
    localparam int NIB = 1 + 2 * TE;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] chr;
    logic       writeChar;
    logic       home;
    logic       ready;
    logic       lcd_rs;
    logic       lcd_rw;
    logic       lcd_e;
    logic [3:0] lcd_data;

    typedef struct {
        int         cyc;
        logic       rs;
        logic [3:0] d;
    } strobe_t;

    typedef struct {
        logic       wc;
        logic       hm;
        logic [7:0] ch;
        logic       rs;
        logic [7:0] code;
        int         wt;
    } vec_t;

    strobe_t    exp_q[$];
    vec_t       vecs[20];
    int         checks = 0;
    int         errors = 0;
    int         cyc;
    int         falls = 0;
    logic       prev_e = 1'b0;
    logic       prev_ready = 1'b0;
    logic       last_rs;
    logic [3:0] last_d;

    lcd_char_driver #(
        .T_POWERUP_CYC   (TP),
        .T_INIT_LONG_CYC (TL),
        .T_SHORT_CYC     (TS),
        .T_EPULSE_CYC    (TE),
        .T_CHAR_CYC      (TC),
        .T_HOME_CYC      (TH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .char      (chr),
        .writeChar (writeChar),
        .home      (home),
        .ready     (ready),
        .lcd_rs    (lcd_rs),
        .lcd_rw    (lcd_rw),
        .lcd_e     (lcd_e),
        .lcd_data  (lcd_data)
    );

    always #5 clk = ~clk;

    // Cycle index: posedges since reset release
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic push(input int c, input logic r, input logic [3:0] dd);
        strobe_t s;
        s.cyc = c;
        s.rs  = r;
        s.d   = dd;
        exp_q.push_back(s);
    endtask

    // Strobe monitor: compares each lcd_e rise against the scoreboard
    always @(negedge clk) begin
        strobe_t s;
        if (rst_n === 1'b1) begin
            if (lcd_e && !prev_e) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_strobe", {27'd0, lcd_rs, lcd_data}, 32'hFFFF_FFFF);
                end else begin
                    s = exp_q.pop_front();
                    check("strobe_cycle", cyc, s.cyc);
                    check("strobe_rs_data", {27'd0, lcd_rs, lcd_data}, {27'd0, s.rs, s.d});
                    check("strobe_rw", {31'd0, lcd_rw}, 32'd0);
                end
                last_rs = lcd_rs;
                last_d  = lcd_data;
            end
            if (!lcd_e && prev_e) begin
                check("strobe_hold", {27'd0, lcd_rs, lcd_data}, {27'd0, last_rs, last_d});
            end
            if (prev_ready && !ready) falls++;
        end
        prev_e     = lcd_e;
        prev_ready = ready;
    end

    task automatic push_init(output int rdy);
        logic [7:0] codes [8];
        int         ws [8];
        int         t;
        codes = '{8'h30, 8'h30, 8'h30, 8'h20, 8'h28, 8'h0C, 8'h01, 8'h06};
        ws    = '{TL, TS, TS, TS, TC, TC, TH, TC};
        t = TP;
        for (int i = 0; i < 4; i++) begin
            push(t + 2, 1'b0, codes[i][7:4]);
            t += 1 + NIB + ws[i];
        end
        for (int i = 4; i < 8; i++) begin
            push(t + 2, 1'b0, codes[i][7:4]);
            push(t + 2 + NIB, 1'b0, codes[i][3:0]);
            t += 1 + 2 * NIB + ws[i];
        end
        rdy = t;
    endtask

    task automatic wait_ready(input string name, input int exp_c);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((ready !== 1'b1) && (n < 400));
        check({name, "_ready"}, {31'd0, ready}, 32'd1);
        check({name, "_cycle"}, cyc, exp_c);
    endtask

    task automatic do_req(input vec_t v, input int idx);
        int acc;
        writeChar = v.wc;
        home      = v.hm;
        chr       = v.ch;
        acc = cyc + 1;
        push(acc + 2, v.rs, v.code[7:4]);
        push(acc + 2 + NIB, v.rs, v.code[3:0]);
        @(negedge clk);
        check($sformatf("req%0d_ready_low", idx), {31'd0, ready}, 32'd0);
        writeChar = 1'b0;
        home      = 1'b0;
        wait_ready($sformatf("req%0d", idx), acc + 1 + 2 * NIB + v.wt);
    endtask

    initial begin
        string line;
        int    rdy;
        int    acc;

        line = "AAAABBBBCCCCABCD";
        vecs[0] = '{1'b1, 1'b0, 8'h41, 1'b1, 8'h41, TC};
        vecs[1] = '{1'b0, 1'b1, 8'h00, 1'b0, 8'h02, TH};
        vecs[2] = '{1'b1, 1'b1, 8'h5A, 1'b0, 8'h02, TH};
        for (int i = 0; i < 16; i++) begin
            vecs[3 + i] = '{1'b1, 1'b0, line[i], 1'b1, line[i], TC};
        end
        vecs[19] = '{1'b0, 1'b1, 8'h33, 1'b0, 8'h02, TH};

        rst_n     = 1'b0;
        writeChar = 1'b0;
        home      = 1'b0;
        chr       = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_ready", {31'd0, ready}, 32'd0);
        check("rst_e", {31'd0, lcd_e}, 32'd0);
        check("rst_rs", {31'd0, lcd_rs}, 32'd0);
        check("rst_rw", {31'd0, lcd_rw}, 32'd0);
        check("rst_data", {28'd0, lcd_data}, 32'd0);

        rst_n = 1'b1;
        push_init(rdy);
        wait_ready("init", rdy);

        for (int i = 0; i < 20; i++) begin
            do_req(vecs[i], i);
        end
        repeat (5) @(negedge clk);
        check("idle_ready", {31'd0, ready}, 32'd1);
        check("ready_falls", falls, 20);
        check("queue_drained", exp_q.size(), 0);

        // Reset while the high nibble of a char write is on the bus
        writeChar = 1'b1;
        chr       = 8'h42;
        acc = cyc + 1;
        push(acc + 2, 1'b1, 4'h4);
        @(negedge clk);
        writeChar = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("midreset_e_before", {31'd0, lcd_e}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("midreset_e", {31'd0, lcd_e}, 32'd0);
        check("midreset_ready", {31'd0, ready}, 32'd0);
        check("midreset_queue", exp_q.size(), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        push_init(rdy);
        wait_ready("reinit", rdy);
        repeat (3) @(negedge clk);
        check("final_queue", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
